// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | disp_scan_ctrl: steps a display index through IM/RF/ALU/DM and fetches   |
// | each word over the shared debug read port.            Rev 1.0            |
// +--------------------------------------------------------------------------+
module disp_scan_ctrl #(
  parameter int IM_DEPTH    = 64,
  parameter int RF_DEPTH    = 32,
  parameter int DM_DEPTH    = 16,
  parameter int ALU_FIELDS  = 4,
  parameter int GNT_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick,
  input  logic [3:0]  view_sel,
  input  logic        freeze,
  output logic [1:0]  src_sel,
  output logic [5:0]  src_addr,
  output logic        rd_req,
  input  logic        rd_gnt,
  input  logic [31:0] rd_data,
  output logic [31:0] disp_data,
  output logic        disp_valid,
  output logic        busy
);

  localparam int             TO_W     = $clog2(GNT_TIMEOUT + 1);
  localparam logic [5:0]     IM_LAST  = 6'(IM_DEPTH - 1);
  localparam logic [5:0]     RF_LAST  = 6'(RF_DEPTH - 1);
  localparam logic [5:0]     ALU_LAST = 6'(ALU_FIELDS - 1);
  localparam logic [5:0]     DM_SENT  = 6'(DM_DEPTH);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GNT_TIMEOUT - 1);
  localparam logic [1:0]     V_IM     = 2'd0;
  localparam logic [1:0]     V_RF     = 2'd1;
  localparam logic [1:0]     V_ALU    = 2'd2;
  localparam logic [1:0]     V_DM     = 2'd3;
  localparam logic [31:0]    SENTINEL = 32'hFFFF_FFFF;
  localparam logic [31:0]    TIMEOUT_WORD = 32'hDEAD_DEAD;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SENT = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [1:0]        view, view_nxt;
  logic [1:0]        sel_q, sel_dec;
  logic [5:0]        idx, idx_nxt, idx_adv;
  logic              load_pend, load_nxt;
  logic [TO_W-1:0]   to_cnt, cnt_nxt;
  logic [31:0]       data_nxt;
  logic              valid_nxt;

  // Zero-hot and multi-hot selections fall back to the instruction ROM.
  always_comb begin
    sel_dec = V_IM;
    unique case (view_sel)
      4'b1000: sel_dec = V_IM;
      4'b0100: sel_dec = V_RF;
      4'b0010: sel_dec = V_ALU;
      4'b0001: sel_dec = V_DM;
      default: sel_dec = V_IM;
    endcase
  end

  always_comb begin
    idx_adv = idx + 6'd1;
    unique case (view)
      V_IM:    if (idx == IM_LAST)  idx_adv = 6'd0;
      V_RF:    if (idx == RF_LAST)  idx_adv = 6'd0;
      V_ALU:   if (idx == ALU_LAST) idx_adv = 6'd0;
      V_DM:    if (idx == DM_SENT)  idx_adv = 6'd0;
      default: idx_adv = 6'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    view_nxt  = view;
    idx_nxt   = idx;
    load_nxt  = load_pend;
    cnt_nxt   = to_cnt;
    data_nxt  = disp_data;
    valid_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (load_pend) begin
          load_nxt  = 1'b0;
          cnt_nxt   = '0;
          state_nxt = REQ;
        end else if (sel_q != view) begin
          // A pending view change outranks a same-cycle tick.
          view_nxt = sel_q;
          idx_nxt  = 6'd0;
          load_nxt = 1'b1;
        end else if (tick && !freeze) begin
          idx_nxt = idx_adv;
          if (view == V_DM && idx_adv == DM_SENT) begin
            data_nxt  = SENTINEL;
            valid_nxt = 1'b1;
            state_nxt = SENT;
          end else begin
            cnt_nxt   = '0;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (rd_gnt) begin
          data_nxt  = rd_data;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          data_nxt  = TIMEOUT_WORD;
          valid_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = to_cnt + TO_W'(1);
        end
      end
      SENT:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      view       <= V_IM;
      sel_q      <= V_IM;
      idx        <= 6'd0;
      load_pend  <= 1'b1;
      to_cnt     <= '0;
      disp_data  <= 32'd0;
      disp_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      view       <= view_nxt;
      sel_q      <= sel_dec;
      idx        <= idx_nxt;
      load_pend  <= load_nxt;
      to_cnt     <= cnt_nxt;
      disp_data  <= data_nxt;
      disp_valid <= valid_nxt;
    end
  end

  assign rd_req   = (state == REQ);
  assign busy     = (state != IDLE);
  assign src_sel  = view;
  assign src_addr = idx;

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_ctrl.sv
`default_nettype none
// Randomized bench for disp_scan_ctrl; a transaction-level scan model predicts every output each cycle.
module tb_disp_scan_ctrl;

  logic        clk = 1'b0;
  logic        rstn, tick, freeze, rd_gnt;
  logic [3:0]  view_sel;
  logic [31:0] rd_data;
  logic [1:0]  src_sel;
  logic [5:0]  src_addr;
  logic        rd_req, disp_valid, busy;
  logic [31:0] disp_data;

  disp_scan_ctrl dut (
    .clk(clk), .rstn(rstn), .tick(tick), .view_sel(view_sel), .freeze(freeze),
    .src_sel(src_sel), .src_addr(src_addr), .rd_req(rd_req), .rd_gnt(rd_gnt),
    .rd_data(rd_data), .disp_data(disp_data), .disp_valid(disp_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: views 0=IM 1=RF 2=ALU 3=DM; activity 0=idle 1=reading 2=showing sentinel.
  int          period [4] = '{64, 32, 4, 17};
  int          m_seen_view, m_view, m_idx, m_activity, m_waited;
  bit          m_load;
  bit          m_valid;
  logic [31:0] m_disp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int decode(input logic [3:0] v);
    if (v == 4'b0100) return 1;
    if (v == 4'b0010) return 2;
    if (v == 4'b0001) return 3;
    return 0;
  endfunction

  task model_reset();
    m_seen_view = 0; m_view = 0; m_idx = 0; m_activity = 0; m_waited = 0;
    m_load = 1'b1; m_valid = 1'b0; m_disp = 32'd0;
  endtask

  task model_step();
    m_valid = 1'b0;
    if (m_activity == 1) begin
      m_waited++;
      if (rd_gnt) begin
        m_disp = rd_data; m_valid = 1'b1; m_activity = 0;
      end else if (m_waited == 15) begin
        m_disp = 32'hDEAD_DEAD; m_valid = 1'b1; m_activity = 0;
      end
    end else if (m_activity == 2) begin
      m_activity = 0;
    end else if (m_load) begin
      m_load = 1'b0; m_activity = 1; m_waited = 0;
    end else if (m_seen_view != m_view) begin
      m_view = m_seen_view; m_idx = 0; m_load = 1'b1;
    end else if (tick && !freeze) begin
      m_idx = (m_idx + 1) % period[m_view];
      if (m_view == 3 && m_idx == 16) begin
        m_disp = 32'hFFFF_FFFF; m_valid = 1'b1; m_activity = 2;
      end else begin
        m_activity = 1; m_waited = 0;
      end
    end
    m_seen_view = decode(view_sel);
  endtask

  task check_outputs();
    check("rd_req", rd_req, m_activity == 1);
    check("busy", busy, m_activity != 0);
    check("disp_data", disp_data, m_disp);
    check("disp_valid", disp_valid, m_valid);
    if (m_activity == 1) begin
      check("src_sel", src_sel, m_view);
      check("src_addr", src_addr, m_idx);
    end
  endtask

  function automatic logic [3:0] pick_view();
    logic [3:0] opts [8] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000, 4'b1100, 4'b0011, 4'b1111};
    return opts[$urandom_range(7)];
  endfunction

  task drive_inputs(input int ph);
    rd_data = $urandom;
    tick    = 1'b0;
    freeze  = 1'b0;
    rd_gnt  = 1'b1;
    case (ph)
      0: tick = ($urandom_range(99) < 30);
      1: tick = ($urandom_range(99) < 50);
      2: begin tick = ($urandom_range(99) < 40); rd_gnt = ($urandom_range(99) < 70); end
      3: begin tick = ($urandom_range(99) < 50); rd_gnt = ($urandom_range(99) < 5); end
      4: begin
        tick   = ($urandom_range(99) < 30);
        freeze = ($urandom_range(99) < 30);
        rd_gnt = ($urandom_range(99) < 50);
        if ($urandom_range(99) < 5) view_sel = pick_view();
      end
      default: begin
        tick   = ($urandom_range(99) < 50);
        freeze = ($urandom_range(99) < 90);
        rd_gnt = ($urandom_range(99) < 60);
        if ($urandom_range(99) < 2) view_sel = pick_view();
      end
    endcase
  endtask

  task pulse_reset();
    rstn = 1'b0;
    #1;
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_disp_data", disp_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  logic [3:0] phase_view [6] = '{4'b1000, 4'b0100, 4'b0001, 4'b0010, 4'b1000, 4'b0100};

  initial begin
    rstn = 1'b0; tick = 1'b0; freeze = 1'b0; rd_gnt = 1'b0;
    view_sel = 4'b1000; rd_data = 32'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rstn = 1'b1; rd_gnt = 1'b1; rd_data = 32'h0050_0093;
    for (int ph = 0; ph < 6; ph++) begin
      view_sel = phase_view[ph];
      for (int cyc = 0; cyc < 600; cyc++) begin
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
        if (ph >= 4 && m_activity == 1 && $urandom_range(99) == 0) pulse_reset();
        if (!(ph == 0 && cyc == 0)) drive_inputs(ph);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
